// File: rtl/mmio_dram.sv
// Data RAM with memory-mapped I/O window: synchronised inputs, strobed outputs, change IRQ.
// Optional change-flag/STAT/MASK/IRQ logic is built only when MMIO_CHANGE_IRQ_EN is defined.
module mmio_dram #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int IO_BASE = 240,
  parameter int N_IN    = 3,
  parameter int N_OUT   = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [ADDR_W-1:0]       ADDR,
  input  logic [DATA_W-1:0]       DATA,
  input  logic                    MW,
  output logic [DATA_W-1:0]       Q,
  input  logic [N_IN*DATA_W-1:0]  IO_IN,
  output logic [N_OUT*DATA_W-1:0] IO_OUT,
  output logic [N_OUT-1:0]        OUT_STB,
  output logic                    IRQ
);

  localparam int OUT_BASE = IO_BASE + N_IN;

  logic [31:0]              addr_i;
  logic [DATA_W-1:0]        mem [IO_BASE];
  logic [N_IN*DATA_W-1:0]   s1, s2;

  assign addr_i = 32'(ADDR);

  // RAM is deliberately left out of reset so contents survive a mid-run reset.
  always_ff @(posedge CLK) begin
    if (MW && addr_i < IO_BASE) mem[ADDR] <= DATA;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      s1      <= '0;
      s2      <= '0;
      IO_OUT  <= '0;
      OUT_STB <= '0;
    end else begin
      s1 <= IO_IN;
      s2 <= s1;
      for (int j = 0; j < N_OUT; j++) begin
        OUT_STB[j] <= MW && (addr_i == OUT_BASE + j);
        if (MW && (addr_i == OUT_BASE + j)) IO_OUT[j*DATA_W +: DATA_W] <= DATA;
      end
    end
  end

`ifdef MMIO_CHANGE_IRQ_EN
  localparam int STAT_ADDR = OUT_BASE + N_OUT;
  localparam int MASK_ADDR = STAT_ADDR + 1;

  logic [N_IN-1:0] flag, mask, chg, clr;

  always_comb begin
    chg = '0;
    clr = '0;
    for (int i = 0; i < N_IN; i++)
      chg[i] = s1[i*DATA_W +: DATA_W] != s2[i*DATA_W +: DATA_W];
    if (MW && addr_i == STAT_ADDR) clr = DATA[N_IN-1:0];
  end

  // A new change in the same cycle as a W1C clear keeps the flag set.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      flag <= '0;
      mask <= '0;
      IRQ  <= 1'b0;
    end else begin
      flag <= (flag & ~clr) | chg;
      if (MW && addr_i == MASK_ADDR) mask <= DATA[N_IN-1:0];
      IRQ  <= |(flag & mask);
    end
  end
`else
  assign IRQ = 1'b0;
`endif

  always_comb begin
    Q = '0;
    if (addr_i < IO_BASE) Q = mem[ADDR];
    for (int i = 0; i < N_IN; i++)
      if (addr_i == IO_BASE + i) Q = s2[i*DATA_W +: DATA_W];
    for (int j = 0; j < N_OUT; j++)
      if (addr_i == OUT_BASE + j) Q = IO_OUT[j*DATA_W +: DATA_W];
`ifdef MMIO_CHANGE_IRQ_EN
    if (addr_i == STAT_ADDR) Q[N_IN-1:0] = flag;
    if (addr_i == MASK_ADDR) Q[N_IN-1:0] = mask;
`endif
  end

endmodule

// File: tb/tb_mmio_dram.sv
// Directed bench for mmio_dram: vector table for RAM/unused decode, hand sequences for I/O timing.
module tb_mmio_dram;

`ifdef MMIO_CHANGE_IRQ_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  ADDR, DATA, Q;
  logic        MW;
  logic [23:0] IO_IN;
  logic [31:0] IO_OUT;
  logic [3:0]  OUT_STB;
  logic        IRQ;

  int errors = 0;
  int checks = 0;

  mmio_dram dut (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .DATA(DATA), .MW(MW), .Q(Q),
    .IO_IN(IO_IN), .IO_OUT(IO_OUT), .OUT_STB(OUT_STB), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       mw;
    logic       chk;
    logic [7:0] exp_q;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] d, input logic w);
    ADDR = a; DATA = d; MW = w;
    #1;
  endtask

  task automatic read(input string name, input logic [7:0] a, input logic [7:0] exp);
    drive(a, 8'h00, 1'b0);
    check(name, {24'h0, Q}, {24'h0, exp});
  endtask

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{8'h10, 8'h5A, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{8'h10, 8'h00, 1'b0, 1'b1, 8'h5A};
    vecs[2]  = '{8'hFC, 8'h00, 1'b0, 1'b1, 8'h00};
    vecs[3]  = '{8'hFC, 8'h77, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{8'hFC, 8'h00, 1'b0, 1'b1, 8'h00};
    vecs[5]  = '{8'hEF, 8'h81, 1'b1, 1'b0, 8'h00};
    vecs[6]  = '{8'hEF, 8'h00, 1'b0, 1'b1, 8'h81};
    vecs[7]  = '{8'h00, 8'hC3, 1'b1, 1'b0, 8'h00};
    vecs[8]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'hC3};
    vecs[9]  = '{8'h10, 8'h00, 1'b0, 1'b1, 8'h5A};
    vecs[10] = '{8'hF9, 8'h66, 1'b1, 1'b0, 8'h00};
    vecs[11] = '{8'hF9, 8'h00, 1'b0, 1'b1, 8'h00};

    RESET = 1'b0; IO_IN = '0; ADDR = '0; DATA = '0; MW = 1'b0;
    #12;
    check("rst_io_out", IO_OUT, 32'h0);
    check("rst_stb", {28'h0, OUT_STB}, 32'h0);
    check("rst_irq", {31'h0, IRQ}, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    tick();
    read("rst_stat", 8'hF7, 8'h00);
    read("rst_mask", 8'hF8, 8'h00);
    check("rst_io_out_rel", IO_OUT, 32'h0);
    check("rst_stb_rel", {28'h0, OUT_STB}, 32'h0);
    check("rst_irq_rel", {31'h0, IRQ}, 32'h0);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].addr, vecs[i].data, vecs[i].mw);
      if (vecs[i].chk) check($sformatf("vec%0d_q", i), {24'h0, Q}, {24'h0, vecs[i].exp_q});
      tick();
    end
    check("unused_wr_no_stb", {28'h0, OUT_STB}, 32'h0);

    // Output port 1 write and strobe
    drive(8'hF4, 8'hA5, 1'b1);
    tick();
    check("out_io", IO_OUT, 32'h0000_A500);
    check("out_stb", {28'h0, OUT_STB}, 32'h2);
    read("out_rd", 8'hF4, 8'hA5);
    tick();
    check("out_stb_drop", {28'h0, OUT_STB}, 32'h0);

    // Back-to-back same-value writes to port 0 hold the strobe high
    drive(8'hF3, 8'h11, 1'b1);
    tick();
    check("b2b_stb1", {28'h0, OUT_STB}, 32'h1);
    tick();
    check("b2b_stb2", {28'h0, OUT_STB}, 32'h1);
    drive(8'h00, 8'h00, 1'b0);
    tick();
    check("b2b_stb_end", {28'h0, OUT_STB}, 32'h0);
    check("b2b_io", IO_OUT, 32'h0000_A511);

    // Input port 2 change with mask bit 2 set
    drive(8'hF8, 8'h04, 1'b1);
    tick();
    read("mask_rd", 8'hF8, EN ? 8'h04 : 8'h00);
    IO_IN[23:16] = 8'h33;
    tick();
    read("sync_e1", 8'hF2, 8'h00);
    read("stat_e1", 8'hF7, 8'h00);
    tick();
    read("sync_e2", 8'hF2, 8'h33);
    read("stat_e2", 8'hF7, EN ? 8'h04 : 8'h00);
    check("irq_e2", {31'h0, IRQ}, 32'h0);
    tick();
    check("irq_e3", {31'h0, IRQ}, {31'h0, EN});
    drive(8'hF7, 8'h04, 1'b1);
    tick();
    read("stat_clr", 8'hF7, 8'h00);
    check("irq_hold", {31'h0, IRQ}, {31'h0, EN});
    tick();
    check("irq_clr", {31'h0, IRQ}, 32'h0);

    // Port 0 change coincides with a W1C of bit 0: set wins
    IO_IN[7:0] = 8'h01;
    tick();
    drive(8'hF7, 8'h01, 1'b1);
    tick();
    read("set_wins", 8'hF7, EN ? 8'h01 : 8'h00);
    read("port0_rd", 8'hF0, 8'h01);
    tick();
    check("irq_masked", {31'h0, IRQ}, 32'h0);

    // Mid-run reset drops an in-flight strobe, keeps RAM
    drive(8'hF5, 8'h42, 1'b1);
    tick();
    check("pre_rst_stb", {28'h0, OUT_STB}, 32'h4);
    drive(8'h00, 8'h00, 1'b0);
    RESET = 1'b0;
    #1;
    check("mid_rst_stb", {28'h0, OUT_STB}, 32'h0);
    check("mid_rst_io", IO_OUT, 32'h0);
    read("mid_rst_stat", 8'hF7, 8'h00);
    read("mid_rst_in", 8'hF2, 8'h00);
    read("ram_kept", 8'h10, 8'h5A);
    @(negedge CLK);
    RESET = 1'b1;
    tick();
    read("boot_stat_e1", 8'hF7, 8'h00);
    tick();
    read("boot_stat_e2", 8'hF7, EN ? 8'h05 : 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_dram.md
# mmio_dram

Parametrised data memory with a memory-mapped I/O window, sitting between the CPU data port and the board pins. It replaces the fixed 3-in/4-out data RAM with configurable data width, address width, window base and input/output port counts. It adds three things: two-flop input synchronisers, per-port output write strobes, and sticky input-change flags that drive a maskable interrupt line.

## Interface
Parameters:
- DATA_W, 8, data and port width in bits
- ADDR_W, 8, address width
- IO_BASE, 240 (0xF0), first I/O address; RAM occupies 0..IO_BASE-1
- N_IN, 3, number of input ports (1..DATA_W)
- N_OUT, 4, number of output ports (>=1); legal only if IO_BASE+N_IN+N_OUT+2 <= 2^ADDR_W

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  asynchronous, active-low reset
- ADDR  in  ADDR_W  data address from the CPU
- DATA  in  DATA_W  write data
- MW  in  1  memory write enable
- Q  out  DATA_W  read data (combinational from ADDR)
- IO_IN  in  N_IN*DATA_W  input pins; port i occupies bits [i*DATA_W +: DATA_W]
- IO_OUT  out  N_OUT*DATA_W  output port registers, same packing
- OUT_STB  out  N_OUT  one-cycle pulse per output port after a write to it
- IRQ  out  1  registered interrupt request

## Operation
Address map, with k = IO_BASE:
- 0..k-1: RAM.
- k..k+N_IN-1: input port i. Read-only; reads return the synchronised value s2[i].
- k+N_IN..k+N_IN+N_OUT-1: output port j. Read/write; reads return IO_OUT[j].
- STAT = k+N_IN+N_OUT: bit i = change flag for input i. Upper bits read 0. Writing 1 to a bit clears that bit (W1C).
- MASK = STAT+1: low N_IN bits are R/W; upper bits read 0.
- Any other address: reads 0, writes ignored.

Behaviour:
- RAM: write on the rising edge when MW=1. Contents are not reset.
- Reads: combinational. Writes take effect at the clock edge, so a read of the same address returns the new value in the cycle after the write edge.
- Synchroniser, per input: s1 <= pin; s2 <= s1.
- Change flag: flag[i] <= (flag[i] & ~clr[i]) | (s1[i] != s2[i]). If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- IRQ <= |(flag & mask).
- OUT_STB[j] <= (MW && ADDR == port j). Writing the same value again still pulses.

## Timing
- Reset (RESET=0, asynchronous): s1, s2, flags, MASK, IO_OUT, OUT_STB and IRQ are all 0. Q then follows the reset state combinationally.
- Pin to readable: a pin change is visible in Q after the 2nd rising edge.
- Change flag: set on that same 2nd edge. IRQ asserts after the 3rd edge if the MASK bit is 1.
- Write to an output port: IO_OUT updates at the write edge. OUT_STB is high for exactly the following cycle.
- Back-to-back writes to the same port give one strobe pulse per write cycle, i.e. a strobe held high continuously.
- MASK write takes effect at the edge. IRQ follows one edge later.
- W1C clear of the last pending bit: the flag drops at the edge, IRQ drops at the next edge.
- Non-zero pins at reset release: flags set 2 edges later. This is intentional, so software clears STAT at boot.
- Reset asserted mid-operation: any in-flight strobe or flag is discarded immediately. RAM is preserved.

## Configuration
- MMIO_CHANGE_IRQ_EN defined: change flags, STAT, MASK and IRQ are implemented as above.
- MMIO_CHANGE_IRQ_EN undefined: no flag or mask registers. STAT and MASK read 0 and writes to them are ignored. IRQ is tied to 0.
- Synchronisers and OUT_STB are present in both builds.

## Test plan
- Reset with IO_IN=0, then release: IO_OUT=0, OUT_STB=0, IRQ=0. Reads of 0xF7 and 0xF8 return 0.
- Write 0x5A to addr 0x10, then read 0x10: Q=0x5A the next cycle. Read 0xFC (unused): Q=0, and a write there changes nothing.
- Write 0xA5 to 0xF4: IO_OUT[15:8]=0xA5 after the edge, OUT_STB=4'b0010 for one cycle, and reading 0xF4 returns 0xA5.
- Drive input port 2 to 0x33 from 0: reading 0xF2 returns 0x33 after 2 edges and STAT=0x04. With MASK=0x04 written beforehand, IRQ=1 one edge later. Writing 0x04 to 0xF7 clears STAT, and IRQ=0 one edge after that.
- Toggle port 0 in the same cycle as a W1C write of 0x01 to STAT: STAT bit 0 remains 1.
- Build without MMIO_CHANGE_IRQ_EN and repeat the previous two scenarios: STAT reads 0 and IRQ stays 0, while the port reads still return 0x33.
